// File: rtl/ram_reader_pkg.sv
// Package: ram_reader_pkg
// Types and constants shared by the RAM stream reader and its output buffer.
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;

    // Entries in the output buffer; the read-issue credit check is sized to this.
    localparam int FIFO_DEPTH = 2;

    // Modular address advance; step is expected to be below depth.
    function automatic logic [31:0] wrapAdd(input logic [31:0] addr,
                                            input logic [31:0] step,
                                            input logic [31:0] depth);
        logic [31:0] sum;
        sum = addr + step;
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Module: skid_fifo2
// Two-entry FIFO with a registered head word. The head register is presented
// directly downstream, so it stays stable while the consumer stalls.
module skid_fifo2
    import ram_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_full;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign w_full = (r_occ == 2'(FIFO_DEPTH));

    // Head/tail shuffle: a push goes straight to the head when it is (or is about to be) free.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (i_push) begin
                        r_head <= i_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && w_pop) begin
                        r_head <= i_data;
                    end else if (i_push) begin
                        r_tail <= i_data;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_data;
                        end else begin
                            r_occ <= 2'd1;
                        end
                    end else if (i_push && !w_full) begin
                        r_tail <= i_data;
                    end
                end
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_data = r_head;

endmodule

// File: rtl/ram_stream_reader.sv
// Module: ram_stream_reader
// Streams `count` words from a 1-cycle-latency RAM read port, starting at
// base_addr, as a valid/ready stream through a 2-entry buffer.
// Optional feature macro: RAM_READER_STRIDE_EN adds a `stride` input that sets
// the address step per read (default step is 1).
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter  int MEM_WIDTH = 32,
    parameter  int MEM_DEPTH = 1024,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      count,
`ifdef RAM_READER_STRIDE_EN
    input  logic [ADDR_W-1:0]    stride,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en_b,
    output logic [ADDR_W-1:0]    ram_addr_b,
    input  logic [MEM_WIDTH-1:0] ram_data_out_b,
    output logic                 m_valid,
    output logic [MEM_WIDTH-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_accepted;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;
`ifdef RAM_READER_STRIDE_EN
    logic [ADDR_W-1:0] r_stride;
`endif

    logic [1:0]           w_occ;
    logic [2:0]           w_pending;
    logic                 w_en;
    logic                 w_pop;
    logic                 w_valid;
    logic                 w_last;
    logic [ADDR_W:0]      w_countClamped;
    logic [ADDR_W-1:0]    w_step;
    logic [ADDR_W-1:0]    w_nextAddr;
    logic [MEM_WIDTH-1:0] w_head;

`ifdef RAM_READER_STRIDE_EN
    assign w_step = r_stride;
`else
    assign w_step = ADDR_W'(1);
`endif

    assign w_countClamped = (count > DEPTH_CNT) ? DEPTH_CNT : count;
    assign w_nextAddr     = ADDR_W'(wrapAdd(32'(r_addr), 32'(w_step), 32'(MEM_DEPTH)));

    // Credit: words already buffered plus the one returning from RAM, minus this cycle's pop.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_en      = (r_state == RUN) && (r_issued != r_count) && (w_pending < 3'(FIFO_DEPTH));

    assign w_valid = (w_occ != 2'd0);
    assign w_pop   = w_valid && m_ready;
    assign w_last  = w_valid && (r_accepted == (r_count - ONE_CNT));

    skid_fifo2 #(
        .WIDTH (MEM_WIDTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_data (ram_data_out_b),
        .o_occ  (w_occ),
        .o_data (w_head)
    );

    // Sequencer FSM with address, issue and accept counters and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef RAM_READER_STRIDE_EN
            r_stride   <= '0;
`endif
        end else begin
            r_inflight <= w_en;
            r_done     <= 1'b0;
            if (w_en) begin
                r_addr   <= w_nextAddr;
                r_issued <= r_issued + ONE_CNT;
            end
            if (w_pop) begin
                r_accepted <= r_accepted + ONE_CNT;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_count    <= w_countClamped;
                        r_issued   <= '0;
                        r_accepted <= '0;
                        r_busy     <= 1'b1;
`ifdef RAM_READER_STRIDE_EN
                        r_stride   <= stride;
`endif
                        r_state    <= (w_countClamped == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_en && ((r_issued + ONE_CNT) == r_count)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ram_en_b   = w_en;
    assign ram_addr_b = r_addr;
    assign m_valid    = w_valid;
    assign m_data     = w_head;
    assign m_last     = w_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench: tb_ram_stream_reader
// Table-driven transfers against a 1-cycle registered RAM model, with a
// scoreboard queue of expected beats plus hand-written reset/ignore sequences.
module tb_ram_stream_reader;

    localparam int MEM_WIDTH    = 32;
    localparam int MEM_DEPTH    = 1024;
    localparam int ADDR_W       = $clog2(MEM_DEPTH);
    localparam int CYCLE_BUDGET = 4000;

    typedef struct {
        int         base;
        int         count;
        int         stride;
        logic [7:0] readyPat;
        bit         pokeStart;
        int         expBeats;
        int         expEnCyc;
        int         expValidCyc;
        int         expDoneCyc;
    } vec_t;

    typedef struct {
        logic [MEM_WIDTH-1:0] data;
        logic                 last;
    } beat_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [ADDR_W-1:0]    baseAddr;
    logic [ADDR_W:0]      count;
`ifdef RAM_READER_STRIDE_EN
    logic [ADDR_W-1:0]    stride;
`endif
    logic                 busy;
    logic                 done;
    logic                 ramEnB;
    logic [ADDR_W-1:0]    ramAddrB;
    logic [MEM_WIDTH-1:0] ramDataOutB = '0;
    logic                 mValid;
    logic [MEM_WIDTH-1:0] mData;
    logic                 mLast;
    logic                 mReady;

    beat_t expQ[$];
    int    expAddr[$];
    int    addrLog[$];
    vec_t  vectors[11];

    int checks   = 0;
    int failures = 0;
    int cyc;
    int beatCount;
    int doneCount;
    int doneCyc;
    int firstEnCyc;
    int firstValidCyc;
    logic busyAt1;
    logic busyAtDone;
    logic prevStall;
    logic [MEM_WIDTH-1:0] prevData;

    ram_stream_reader #(
        .MEM_WIDTH (MEM_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .base_addr      (baseAddr),
        .count          (count),
`ifdef RAM_READER_STRIDE_EN
        .stride         (stride),
`endif
        .busy           (busy),
        .done           (done),
        .ram_en_b       (ramEnB),
        .ram_addr_b     (ramAddrB),
        .ram_data_out_b (ramDataOutB),
        .m_valid        (mValid),
        .m_data         (mData),
        .m_last         (mLast),
        .m_ready        (mReady)
    );

    always #5 clock = ~clock;

    // RAM port B model: registered read, word i holds A000_0000 + i.
    always @(posedge clock) begin
        if (ramEnB) begin
            ramDataOutB <= 32'hA000_0000 + 32'(ramAddrB);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_ram_en_b"}, 64'(ramEnB), 64'd0);
        checkOutput({tag, "_ram_addr_b"}, 64'(ramAddrB), 64'd0);
        checkOutput({tag, "_m_valid"}, 64'(mValid), 64'd0);
        checkOutput({tag, "_m_data"}, 64'(mData), 64'd0);
        checkOutput({tag, "_m_last"}, 64'(mLast), 64'd0);
    endtask

    task automatic clearMonitor();
        cyc           = 0;
        beatCount     = 0;
        doneCount     = 0;
        doneCyc       = -1;
        firstEnCyc    = -1;
        firstValidCyc = -1;
        busyAt1       = 1'b0;
        busyAtDone    = 1'b1;
        prevStall     = 1'b0;
        prevData      = '0;
        addrLog.delete();
    endtask

    task automatic loadExpected(input int base, input int beats, input int strd);
        int a;
        beat_t b;
        expQ.delete();
        expAddr.delete();
        for (int i = 0; i < beats; i++) begin
            a      = (base + i * strd) % MEM_DEPTH;
            b.data = 32'hA000_0000 + 32'(a);
            b.last = (i == beats - 1);
            expAddr.push_back(a);
            expQ.push_back(b);
        end
    endtask

    // Samples one cycle at the falling edge, then advances to just after the next rising edge.
    task automatic sampleCycle();
        beat_t e;
        @(negedge clock);
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (cyc == 1) busyAt1 = busy;
            if (ramEnB) begin
                addrLog.push_back(int'(ramAddrB));
                if (firstEnCyc < 0) firstEnCyc = cyc;
            end
            if (mValid && firstValidCyc < 0) firstValidCyc = cyc;
            if (done) begin
                doneCount++;
                doneCyc    = cyc;
                busyAtDone = busy;
            end
            if (prevStall) begin
                checkOutput("stall_hold_valid", 64'(mValid), 64'd1);
                checkOutput("stall_hold_data", 64'(mData), 64'(prevData));
            end
            if (mValid && mReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL beat_extra: got beat 0x%0h, expected no beat", mData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat_data", 64'(mData), 64'(e.data));
                    checkOutput("beat_last", 64'(mLast), 64'(e.last));
                    beatCount++;
                end
            end
            prevStall = mValid && !mReady;
            prevData  = mData;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input vec_t v);
        int effStride;
        int budget;
`ifdef RAM_READER_STRIDE_EN
        effStride = v.stride;
        stride    = ADDR_W'(v.stride);
`else
        effStride = 1;
`endif
        clearMonitor();
        loadExpected(v.base, v.expBeats, effStride);
        baseAddr = ADDR_W'(v.base);
        count    = (ADDR_W+1)'(v.count);
        start    = 1'b1;
        mReady   = v.readyPat[0];
        sampleCycle();
        start    = 1'b0;
        baseAddr = ADDR_W'($urandom);
        count    = (ADDR_W+1)'($urandom);
        budget   = 0;
        while (doneCount == 0 && budget < CYCLE_BUDGET) begin
            start  = v.pokeStart && (cyc == 2);
            mReady = v.readyPat[cyc % 8];
            sampleCycle();
            budget++;
        end
        start = 1'b0;
        if (doneCount == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected a done pulse", budget);
        end
        repeat (2) sampleCycle();
        checkOutput("done_pulses", 64'(doneCount), 64'd1);
        checkOutput("beats_left", 64'(expQ.size()), 64'd0);
        checkOutput("beat_count", 64'(beatCount), 64'(v.expBeats));
        checkOutput("addr_count", 64'(addrLog.size()), 64'(expAddr.size()));
        for (int i = 0; i < addrLog.size() && i < expAddr.size(); i++) begin
            checkOutput("ram_addr", 64'(addrLog[i]), 64'(expAddr[i]));
        end
        checkOutput("busy_after_start", 64'(busyAt1), 64'd1);
        checkOutput("busy_at_done", 64'(busyAtDone), 64'd0);
        if (v.expDoneCyc >= 0) begin
            checkOutput("first_en_cycle", 64'(firstEnCyc), 64'(v.expEnCyc));
            checkOutput("first_valid_cycle", 64'(firstValidCyc), 64'(v.expValidCyc));
            checkOutput("done_cycle", 64'(doneCyc), 64'(v.expDoneCyc));
        end
    endtask

    initial begin
        int budget;
        reset    = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        count    = '0;
        mReady   = 1'b0;
`ifdef RAM_READER_STRIDE_EN
        stride   = ADDR_W'(1);
`endif
        //            base  count stride ready        poke beats en valid done
        vectors[0]  = '{4,    3,    1, 8'hFF,       1'b0, 3,    1,  3,  7};
        vectors[1]  = '{1022, 4,    1, 8'hFF,       1'b0, 4,    1,  3,  8};
        vectors[2]  = '{100,  8,    1, 8'b10011001, 1'b0, 8,   -1, -1, -1};
        vectors[3]  = '{0,    0,    1, 8'hFF,       1'b0, 0,   -1, -1,  2};
        vectors[4]  = '{10,   4,    1, 8'hFF,       1'b1, 4,    1,  3,  8};
        vectors[5]  = '{1000, 16,   1, 8'b01010101, 1'b0, 16,  -1, -1, -1};
        vectors[6]  = '{500,  5,    1, 8'b00000001, 1'b0, 5,   -1, -1, -1};
        vectors[7]  = '{7,    2000, 1, 8'hFF,       1'b0, 1024, 1,  3, 1028};
        vectors[8]  = '{0,    4,    3, 8'hFF,       1'b0, 4,    1,  3,  8};
        vectors[9]  = '{5,    2,    0, 8'hFF,       1'b0, 2,    1,  3,  6};
        vectors[10] = '{1023, 1,    1, 8'b00000110, 1'b0, 1,   -1, -1, -1};

        clearMonitor();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkIdleOutputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) sampleCycle();

        for (int n = 0; n < 11; n++) begin
            applyStimulus(vectors[n]);
        end

        // Reset in the middle of a 6-word transfer after two beats were taken.
        clearMonitor();
        loadExpected(50, 6, 1);
`ifdef RAM_READER_STRIDE_EN
        stride = ADDR_W'(1);
`endif
        baseAddr = ADDR_W'(50);
        count    = (ADDR_W+1)'(6);
        start    = 1'b1;
        mReady   = 1'b1;
        sampleCycle();
        start  = 1'b0;
        budget = 0;
        while (beatCount < 2 && budget < 50) begin
            sampleCycle();
            budget++;
        end
        checkOutput("beats_before_reset", 64'(beatCount), 64'd2);
        reset = 1'b1;
        sampleCycle();
        reset = 1'b0;
        @(negedge clock);
        checkIdleOutputs("mid_reset");
        @(posedge clock);
        #1;
        expQ.delete();
        repeat (6) sampleCycle();
        checkOutput("no_done_after_reset", 64'(doneCount), 64'd0);
        checkOutput("no_beat_after_reset", 64'(beatCount), 64'd2);

        applyStimulus(vectors[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
